ascon_hash_xof_stream: RTL and testbench

- Streaming Ascon-Hash / Ascon-Xof engine with its own iterated permutation core.
- Message words enter on a valid/ready interface, with padding applied in hardware. Digest or XOF words leave on a valid/ready interface.
- Generalises the fixed-message, fixed-256-bit controller: runtime message length, runtime mode, runtime output length, parametrised round counts and unroll.
- Sits between the bus-side message FIFO and the digest consumer.

---
 rtl/ascon_hash_xof_stream.sv | 235 +++++++++++++++++++++++
 tb/tb_ascon_hash_xof_stream.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_hash_xof_stream.sv
// Streaming Ascon-Hash / Ascon-Xof engine with an iterated, optionally unrolled permutation core.
// Message words are absorbed over a valid/ready port with hardware padding; digest or XOF
// words are squeezed out over a second valid/ready port.
module ascon_hash_xof_stream #(
  parameter int unsigned ROUNDS_A = 12,
  parameter int unsigned ROUNDS_B = 12,
  parameter int unsigned UNROLL   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode,
  input  logic [7:0]  out_words,
  input  logic [63:0] msg_data,
  input  logic        msg_valid,
  input  logic        msg_last,
  input  logic [3:0]  msg_bytes,
  output logic        msg_ready,
  output logic [63:0] out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    StIdle, StInit, StAbsorb, StPermB, StPad, StPermA, StSqueeze, StPermSq
  } state_e;

  // Index 0 is x0, the rate word.
  typedef logic [4:0][63:0] ascon_state_t;

  // A permutation p^n runs global round indices 12-n .. 11.
  localparam logic [3:0] RndAStart = 4'(12 - ROUNDS_A);
  localparam logic [3:0] RndBStart = 4'(12 - ROUNDS_B);
  localparam logic [3:0] RndStep   = 4'(UNROLL);
  localparam logic [7:0] IvCap     = 8'(12 - ROUNDS_B);

  state_e       state_q;
  ascon_state_t s_q;
  logic [3:0]   rnd_q;
  logic         mode_q;
  logic [7:0]   target_q;
  logic [7:0]   cnt_q;
  logic         pad_pending_q;
  logic         msg_ready_q;
  logic         out_valid_q;
  logic         out_last_q;
  logic [63:0]  out_data_q;
  logic         busy_q;

  ascon_state_t perm;
  logic [3:0]   rnd_next;
  logic         perm_done;
  logic [3:0]   nb;
  logic [63:0]  keep_mask;
  logic [63:0]  pad_word;
  logic [63:0]  last_word;
  logic [63:0] iv;

  function automatic logic [63:0] ror64(logic [63:0] v, int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic ascon_state_t ascon_round(ascon_state_t s, logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'd0, 4'hf - idx, idx};
    x3 = s[3];
    x4 = s[4];
    // Bitsliced 5-bit S-box
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    // Linear diffusion layer
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1) ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7) ^ ror64(x4, 41);
    return {x4, x3, x2, x1, x0};
  endfunction

  // UNROLL consecutive rounds starting at the current round index
  always_comb begin
    perm = s_q;
    for (int unsigned k = 0; k < UNROLL; k++) begin
      perm = ascon_round(perm, rnd_q + 4'(k));
    end
    rnd_next  = rnd_q + RndStep;
    perm_done = (rnd_next == 4'd12);
  end

  // Tail masking and 0x80 padding of a short final word; oversize byte counts clamp to 8
  always_comb begin
    nb        = (msg_bytes > 4'd8) ? 4'd8 : msg_bytes;
    keep_mask = ~(64'hffff_ffff_ffff_ffff >> {nb, 3'b000});
    pad_word  = 64'h80 << {3'd7 - nb[2:0], 3'b000};
    last_word = (msg_data & keep_mask) | pad_word;
    iv        = {8'd0, 8'd64, 8'd12, IvCap, (mode ? 32'd0 : 32'd256)};
  end

  // Control FSM, permutation state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      s_q           <= '0;
      rnd_q         <= '0;
      mode_q        <= 1'b0;
      target_q      <= '0;
      cnt_q         <= '0;
      pad_pending_q <= 1'b0;
      msg_ready_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            s_q           <= {64'd0, 64'd0, 64'd0, 64'd0, iv};
            mode_q        <= mode;
            target_q      <= mode ? ((out_words == 8'd0) ? 8'd1 : out_words) : 8'd4;
            rnd_q         <= RndAStart;
            pad_pending_q <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= StInit;
          end
        end
        StInit: begin
          s_q   <= perm;
          rnd_q <= rnd_next;
          if (perm_done) begin
            msg_ready_q <= 1'b1;
            state_q     <= StAbsorb;
          end
        end
        StAbsorb: begin
          if (msg_valid) begin
            msg_ready_q <= 1'b0;
            if (msg_last && nb != 4'd8) begin
              s_q[0]  <= s_q[0] ^ last_word;
              rnd_q   <= RndAStart;
              state_q <= StPermA;
            end else begin
              // A full final word still needs a separate padding block
              s_q[0]        <= s_q[0] ^ msg_data;
              pad_pending_q <= msg_last;
              rnd_q         <= RndBStart;
              state_q       <= StPermB;
            end
          end
        end
        StPermB: begin
          s_q   <= perm;
          rnd_q <= rnd_next;
          if (perm_done) begin
            if (pad_pending_q) begin
              pad_pending_q <= 1'b0;
              state_q       <= StPad;
            end else begin
              msg_ready_q <= 1'b1;
              state_q     <= StAbsorb;
            end
          end
        end
        StPad: begin
          s_q[0]  <= s_q[0] ^ 64'h8000_0000_0000_0000;
          rnd_q   <= RndAStart;
          state_q <= StPermA;
        end
        StPermA: begin
          s_q   <= perm;
          rnd_q <= rnd_next;
          if (perm_done) begin
            cnt_q       <= 8'd1;
            out_valid_q <= 1'b1;
            out_data_q  <= perm[0];
            out_last_q  <= (target_q == 8'd1);
            state_q     <= StSqueeze;
          end
        end
        StSqueeze: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            if (out_last_q) begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              cnt_q   <= cnt_q + 8'd1;
              rnd_q   <= RndBStart;
              state_q <= StPermSq;
            end
          end
        end
        StPermSq: begin
          s_q   <= perm;
          rnd_q <= rnd_next;
          if (perm_done) begin
            out_valid_q <= 1'b1;
            out_data_q  <= perm[0];
            out_last_q  <= (cnt_q == target_q);
            state_q     <= StSqueeze;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign msg_ready = msg_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ascon_hash_xof_stream.sv
// Bench for ascon_hash_xof_stream: a default Ascon-Hash/Xof instance and an Ascon-Hasha/Xofa
// instance (UNROLL=4, ROUNDS_B=8) checked against a byte-level sponge model with a table S-box.
module tb_ascon_hash_xof_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [7:0]  out_words;
  logic [63:0] msg_data;
  logic        msg_valid;
  logic        msg_last;
  logic [3:0]  msg_bytes;
  logic        out_ready;
  logic        sel;

  logic        m_msg_ready, m_out_valid, m_out_last, m_busy;
  logic [63:0] m_out_data;
  logic        a_msg_ready, a_out_valid, a_out_last, a_busy;
  logic [63:0] a_out_data;

  logic        msg_ready, out_valid, out_last, busy;
  logic [63:0] out_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ascon_hash_xof_stream dut (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .mode(mode), .out_words(out_words),
    .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last), .msg_bytes(msg_bytes),
    .msg_ready(m_msg_ready), .out_data(m_out_data), .out_valid(m_out_valid),
    .out_last(m_out_last), .out_ready(out_ready), .busy(m_busy)
  );

  ascon_hash_xof_stream #(.ROUNDS_A(12), .ROUNDS_B(8), .UNROLL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .mode(mode), .out_words(out_words),
    .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last), .msg_bytes(msg_bytes),
    .msg_ready(a_msg_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_last(a_out_last), .out_ready(out_ready), .busy(a_busy)
  );

  assign msg_ready = sel ? a_msg_ready : m_msg_ready;
  assign out_valid = sel ? a_out_valid : m_out_valid;
  assign out_last  = sel ? a_out_last  : m_out_last;
  assign out_data  = sel ? a_out_data  : m_out_data;
  assign busy      = sel ? a_busy      : m_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- Reference model: byte-level sponge ----------------
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic [63:0] ms [5];
  logic [7:0]  mq [$];
  logic [63:0] mout [$];
  logic [64:0] expq [$];

  function automatic logic [63:0] rorm(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic void m_perm(input int nr);
    logic [4:0] col, o;
    for (int r = 12 - nr; r < 12; r++) begin
      ms[2] = ms[2] ^ 64'(240 - 15 * r);
      for (int b = 0; b < 64; b++) begin
        col = {ms[0][b], ms[1][b], ms[2][b], ms[3][b], ms[4][b]};
        o = SBOX[col];
        ms[0][b] = o[4];
        ms[1][b] = o[3];
        ms[2][b] = o[2];
        ms[3][b] = o[1];
        ms[4][b] = o[0];
      end
      ms[0] = ms[0] ^ rorm(ms[0], 19) ^ rorm(ms[0], 28);
      ms[1] = ms[1] ^ rorm(ms[1], 61) ^ rorm(ms[1], 39);
      ms[2] = ms[2] ^ rorm(ms[2], 1) ^ rorm(ms[2], 6);
      ms[3] = ms[3] ^ rorm(ms[3], 10) ^ rorm(ms[3], 17);
      ms[4] = ms[4] ^ rorm(ms[4], 7) ^ rorm(ms[4], 41);
    end
  endfunction

  function automatic void model_run(input bit md, input int ow, input int rb);
    logic [7:0]  p [$];
    logic [63:0] blk;
    int nblk, n;
    p = mq;
    p.push_back(8'h80);
    while (p.size() % 8 != 0) p.push_back(8'h00);
    ms[0] = {8'd0, 8'd64, 8'd12, 8'(12 - rb), (md ? 32'd0 : 32'd256)};
    for (int i = 1; i < 5; i++) ms[i] = 64'd0;
    m_perm(12);
    nblk = p.size() / 8;
    for (int k = 0; k < nblk; k++) begin
      blk = 64'd0;
      for (int j = 0; j < 8; j++) blk = {blk[55:0], p[8 * k + j]};
      ms[0] = ms[0] ^ blk;
      m_perm((k == nblk - 1) ? 12 : rb);
    end
    n = md ? ((ow == 0) ? 1 : ow) : 4;
    mout.delete();
    for (int k = 0; k < n; k++) begin
      mout.push_back(ms[0]);
      if (k != n - 1) m_perm(rb);
    end
  endfunction

  task automatic set_msg(input int len, input int seed);
    mq.delete();
    for (int k = 0; k < len; k++) mq.push_back(8'(k * 7 + seed));
  endtask

  // ---------------- Output compare process ----------------
  logic [63:0] prev_data;
  logic        prev_stall = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_word: got %h with no word outstanding", out_data);
        end else begin
          chk("out_data", out_data, expq[0][63:0]);
          chk("out_last", 64'(out_last), 64'(expq[0][64]));
          if (out_ready) void'(expq.pop_front());
        end
        if (prev_stall) chk("stall_hold", out_data, prev_data);
      end
      if (!busy) chk("idle_outputs", 64'({msg_ready, out_valid, out_last}), 64'd0);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // ---------------- Drivers ----------------
  task automatic do_start(input bit md, input int ow, input int u);
    int n;
    mode      = md;
    out_words = 8'(ow);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    mode      = ~md;     // must have been latched
    out_words = 8'hff;
    chk("busy_after_start", 64'(busy), 64'd1);
    n = 0;
    while (!msg_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk("init_latency", 64'(n), 64'(12 / u));
  endtask

  task automatic send_msg(input int gaps, input bit big, input int u, input int rb);
    int len, nw, nb_last, n, g;
    logic [63:0] w;
    len     = mq.size();
    nw      = (len == 0) ? 1 : (len + 7) / 8;
    nb_last = len - 8 * (nw - 1);
    for (int k = 0; k < nw; k++) begin
      w = 64'd0;
      for (int j = 0; j < 8; j++) begin
        if (8 * k + j < len) w = {w[55:0], mq[8 * k + j]};
        else w = {w[55:0], 8'ha5};  // junk beyond the tail must be masked
      end
      msg_data  = w;
      msg_last  = (k == nw - 1);
      if (k == nw - 1) msg_bytes = (big && nb_last == 8) ? 4'd15 : 4'(nb_last);
      else msg_bytes = 4'(k % 9);
      msg_valid = 1'b1;
      n = 0;
      while (!msg_ready && n < 500) begin @(posedge clk); #1; n++; end
      chk("msg_ready_timeout", 64'(n < 500), 64'd1);
      @(posedge clk); #1;
      msg_valid = 1'b0;
      msg_last  = 1'b0;
      msg_data  = 64'hdead_beef_dead_beef;
      if (gaps > 0 && k != nw - 1) begin
        g = int'($urandom_range(gaps, 0));
        repeat (g) begin @(posedge clk); #1; end
      end
    end
    n = 0;
    while (!out_valid && n < 500) begin @(posedge clk); #1; n++; end
    chk("final_latency", 64'(n), 64'((nb_last == 8) ? (rb / u + 1 + 12 / u) : 12 / u));
  endtask

  task automatic run(input bit md, input int ow, input int gaps, input bit bp, input bit big);
    int rb, u, n;
    rb = sel ? 8 : 12;
    u  = sel ? 4 : 1;
    model_run(md, ow, rb);
    for (int k = 0; k < mout.size(); k++) expq.push_back({(k == mout.size() - 1), mout[k]});
    if (bp) out_ready = 1'b0;
    do_start(md, ow, u);
    send_msg(gaps, big, u, rb);
    if (bp) begin
      repeat (20) begin
        @(posedge clk); #1;
        if (n == 5) start = 1'b1;  // ignored while busy
        else start = 1'b0;
        mode = 1'b1;
        n++;
      end
      start = 1'b0;
      chk("busy_during_stall", 64'(busy), 64'd1);
      out_ready = 1'b1;
    end
    n = 0;
    while (busy && n < 2000) begin @(posedge clk); #1; n++; end
    chk("run_done", 64'(busy), 64'd0);
    chk("words_left", 64'(expq.size()), 64'd0);
    expq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; out_words = 8'd0; msg_data = 64'd0;
    msg_valid = 1'b0; msg_last = 1'b0; msg_bytes = 4'd0; out_ready = 1'b1; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags_m", 64'({m_msg_ready, m_out_valid, m_out_last, m_busy}), 64'd0);
    chk("reset_data_m", m_out_data, 64'd0);
    chk("reset_flags_a", 64'({a_msg_ready, a_out_valid, a_out_last, a_busy}), 64'd0);
    chk("reset_data_a", a_out_data, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the model to the published empty-message Ascon-Hash digest
    set_msg(0, 0);
    model_run(1'b0, 0, 12);
    chk("model_empty_w0", mout[0], 64'h7346bc14f036e87a);
    chk("model_empty_w1", mout[1], 64'he03d0997913088f5);
    chk("model_empty_w2", mout[2], 64'hf68411434b3cf8b5);
    chk("model_empty_w3", mout[3], 64'h4fa796a80d251f91);

    // Ascon-Hash instance
    set_msg(0, 0);  run(1'b0, 0, 0, 1'b0, 1'b0);  // empty
    set_msg(8, 1);  run(1'b0, 0, 0, 1'b0, 1'b0);  // one full word, extra pad block
    set_msg(9, 2);  run(1'b0, 0, 0, 1'b0, 1'b0);  // two words, 1-byte tail
    set_msg(20, 3); run(1'b1, 2, 0, 1'b0, 1'b0);  // xof, 2 words
    set_msg(20, 3); run(1'b1, 6, 0, 1'b0, 1'b0);  // same message, 6 words
    set_msg(20, 3); run(1'b1, 0, 0, 1'b0, 1'b0);  // out_words=0 -> 1 word
    set_msg(29, 4); run(1'b0, 0, 3, 1'b1, 1'b0);  // valid gaps + backpressure + stray start
    set_msg(16, 5); run(1'b0, 0, 0, 1'b0, 1'b1);  // msg_bytes=15 treated as 8

    // Reset in the middle of absorbing
    do_start(1'b0, 0, 1);
    msg_data = 64'h0123_4567_89ab_cdef; msg_last = 1'b0; msg_bytes = 4'd0; msg_valid = 1'b1;
    n = 0;
    while (!msg_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    msg_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("abort_flags", 64'({m_msg_ready, m_out_valid, m_out_last, m_busy}), 64'd0);
    chk("abort_data", m_out_data, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_msg(5, 6);  run(1'b0, 0, 0, 1'b0, 1'b0);

    // Ascon-Hasha / Xofa instance
    sel = 1'b1;
    @(posedge clk); #1;
    set_msg(0, 0);  run(1'b0, 0, 0, 1'b0, 1'b0);
    set_msg(9, 7);  run(1'b0, 0, 0, 1'b0, 1'b0);
    set_msg(16, 8); run(1'b0, 0, 2, 1'b0, 1'b0);
    set_msg(10, 9); run(1'b1, 3, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
